// File: rtl/fft_input_packer.sv
// fft_input_packer: packs serial I/Q samples into NUM-lane blocks with block/frame markers for the FFT.
// Optional macro FFT_PACK_FRAME_SYNC_EN adds sof_in frame resynchronisation and a sync_err pulse.
module fft_input_packer #(
  parameter  int WIDTH = 9,
  parameter  int NUM   = 16,
  parameter  int DATA  = 512,
  localparam int BLK_W = $clog2(DATA/NUM)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [WIDTH-1:0]   din_i,
  input  logic signed [WIDTH-1:0]   din_q,
  input  logic                      valid_in,
`ifdef FFT_PACK_FRAME_SYNC_EN
  input  logic                      sof_in,
  output logic                      sync_err,
`endif
  output logic [NUM-1:0][WIDTH-1:0] do_i,
  output logic [NUM-1:0][WIDTH-1:0] do_q,
  output logic                      valid_out,
  output logic [BLK_W-1:0]          blk_idx,
  output logic                      sof_out,
  output logic                      eof_out
);

  localparam int CNT_W = $clog2(NUM);
  localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'(NUM-1);
  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(DATA/NUM-1);

  logic [NUM-1:0][WIDTH-1:0] stg_i_p0, stg_q_p0;
  logic [NUM-1:0][WIDTH-1:0] blk_i, blk_q;
  logic [NUM-1:0][WIDTH-1:0] do_i_p1, do_q_p1;
  logic [CNT_W-1:0]          smp_cnt;
  logic [BLK_W-1:0]          blk_cnt;
  logic [BLK_W-1:0]          blk_idx_p1;
  logic                      vld_p1, sof_p1, eof_p1;
  logic                      resync;
  logic [CNT_W-1:0]          wr_lane;

`ifdef FFT_PACK_FRAME_SYNC_EN
  logic sync_err_p1;
  assign resync = valid_in && sof_in && ((smp_cnt != '0) || (blk_cnt != '0));
`else
  assign resync = 1'b0;
`endif

  assign wr_lane = resync ? '0 : smp_cnt;

  // The completing sample bypasses staging so the block is presented one cycle after it.
  always_comb begin
    blk_i = stg_i_p0;
    blk_q = stg_q_p0;
    blk_i[NUM-1] = din_i;
    blk_q[NUM-1] = din_q;
  end

  // Stage p0: staging lanes
  always_ff @(posedge clk) begin
    if (valid_in) begin
      stg_i_p0[wr_lane] <= din_i;
      stg_q_p0[wr_lane] <= din_q;
    end
  end

  // Stage p1: counters and presented block
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_cnt    <= '0;
      blk_cnt    <= '0;
      vld_p1     <= 1'b0;
      sof_p1     <= 1'b0;
      eof_p1     <= 1'b0;
      blk_idx_p1 <= '0;
      do_i_p1    <= '0;
      do_q_p1    <= '0;
`ifdef FFT_PACK_FRAME_SYNC_EN
      sync_err_p1 <= 1'b0;
`endif
    end else begin
      vld_p1 <= 1'b0;
      sof_p1 <= 1'b0;
      eof_p1 <= 1'b0;
`ifdef FFT_PACK_FRAME_SYNC_EN
      sync_err_p1 <= resync;
`endif
      if (valid_in) begin
        if (resync) begin
          smp_cnt <= CNT_W'(1);
          blk_cnt <= '0;
        end else begin
          smp_cnt <= smp_cnt + 1'b1;
          if (smp_cnt == LAST_SMP) begin
            do_i_p1    <= blk_i;
            do_q_p1    <= blk_q;
            vld_p1     <= 1'b1;
            blk_idx_p1 <= blk_cnt;
            sof_p1     <= (blk_cnt == '0);
            eof_p1     <= (blk_cnt == LAST_BLK);
            blk_cnt    <= (blk_cnt == LAST_BLK) ? '0 : blk_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign do_i      = do_i_p1;
  assign do_q      = do_q_p1;
  assign valid_out = vld_p1;
  assign blk_idx   = blk_idx_p1;
  assign sof_out   = sof_p1;
  assign eof_out   = eof_p1;
`ifdef FFT_PACK_FRAME_SYNC_EN
  assign sync_err  = sync_err_p1;
`endif

endmodule
